// File: rtl/shift_add_mult_seq_if.sv
// Operand/result bundle between the shift-add multiplier sequencer and its environment.
// slave = sequencer side, master = requester plus external 9-bit add/subtract stage.
interface shift_add_mult_seq_if;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Din;
    logic [8:0] add_sum;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_sub;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       Busy;
    logic       Done;

    modport slave (
        input  Run, ClearA_LoadB, Din, add_sum,
        output add_a, add_b, add_sub, Aval, Bval, X, Busy, Done
    );

    modport master (
        output Run, ClearA_LoadB, Din, add_sum,
        input  add_a, add_b, add_sub, Aval, Bval, X, Busy, Done
    );
endinterface

// File: rtl/shift_add_mult_seq.sv
// Sequencer and X/A/B/S register file for an 8x8 signed shift-add multiplier.
// Optional build macro MULT_ZERO_SKIP_EN folds the shift into ADD when B[0]=0.
module shift_add_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    shift_add_mult_seq_if.slave  mult_if
);

    // The paired adder is a fixed 8+1 bit stage, so no other width can work.
    if (WIDTH != 8) begin : g_width_check
        $error("shift_add_mult_seq: only WIDTH=8 is supported");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             x_q, x_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sub_q, sub_d;
    logic [2*WIDTH-1:0] shifted_s;

    // Arithmetic right shift of X:A:B; X is replicated into A[7].
    function automatic logic [2*WIDTH-1:0] asr_xab(input logic x,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        return {x, a, b[WIDTH-1:1]};
    endfunction

    assign shifted_s = asr_xab(x_q, a_q, b_q);

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            s_q     <= {WIDTH{1'b0}};
            x_q     <= 1'b0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sub_q   <= sub_d;
        end
    end

    // Next-state and datapath update for the IDLE/ADD/SHIFT/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        x_d     = x_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (mult_if.ClearA_LoadB) begin
                    a_d = {WIDTH{1'b0}};
                    x_d = 1'b0;
                    b_d = mult_if.Din;
                end else if (mult_if.Run) begin
                    s_d     = mult_if.Din;
                    a_d     = {WIDTH{1'b0}};
                    x_d     = 1'b0;
                    cnt_d   = 3'd0;
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (b_q[0]) begin
                    x_d     = mult_if.add_sum[WIDTH];
                    a_d     = mult_if.add_sum[WIDTH-1:0];
                    state_d = ST_SHIFT;
                end else begin
`ifdef MULT_ZERO_SKIP_EN
                    // Nothing to add: shift now and decide on the next iteration here.
                    a_d = shifted_s[2*WIDTH-1:WIDTH];
                    b_d = shifted_s[WIDTH-1:0];
                    if (cnt_q == 3'd7) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        state_d = ST_ADD;
                    end
`else
                    state_d = ST_SHIFT;
`endif
                end
            end
            ST_SHIFT: begin
                a_d = shifted_s[2*WIDTH-1:WIDTH];
                b_d = shifted_s[WIDTH-1:0];
                if (cnt_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                if (!mult_if.Run) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status and adder-control flags are registered from the next state.
    always_comb begin
        busy_d = (state_d == ST_ADD) || (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
        sub_d  = (state_d == ST_ADD) && (cnt_d == 3'd7);
    end

    assign mult_if.add_a   = a_q;
    assign mult_if.add_b   = s_q;
    assign mult_if.add_sub = sub_q;
    assign mult_if.Aval    = a_q;
    assign mult_if.Bval    = b_q;
    assign mult_if.X       = x_q;
    assign mult_if.Busy    = busy_q;
    assign mult_if.Done    = done_q;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Directed plus random bench for shift_add_mult_seq with a behavioural 9-bit adder
// and a product model based on plain signed multiplication.
module tb_shift_add_mult_seq;

    logic Clk;
    logic Reset_n;
    int   total;
    int   bad;
    logic [7:0] b_ref;

    shift_add_mult_seq_if bus ();

    shift_add_mult_seq #(.WIDTH(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .mult_if (bus.slave)
    );

    // External add/subtract stage: 9-bit signed A +/- S.
    assign bus.add_sum = bus.add_sub ? ({bus.add_a[7], bus.add_a} - {bus.add_b[7], bus.add_b})
                                     : ({bus.add_a[7], bus.add_a} + {bus.add_b[7], bus.add_b});

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic int popcnt8(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    // Edges counted from the Run-sampling edge (edge 1) to the edge that raises Done.
    function automatic int exp_latency(input logic [7:0] b);
`ifdef MULT_ZERO_SKIP_EN
        return 9 + popcnt8(b);
`else
        return 17;
`endif
    endfunction

    function automatic int exp_sub_edge(input logic [7:0] b, input int lat);
`ifdef MULT_ZERO_SKIP_EN
        return b[7] ? lat - 2 : lat - 1;
`else
        return (b[7] == b[7]) ? lat - 2 : lat - 2;
`endif
    endfunction

    task automatic load_b(input logic [7:0] v);
        bus.ClearA_LoadB = 1'b1;
        bus.Din          = v;
        step();
        bus.ClearA_LoadB = 1'b0;
        b_ref            = v;
        chk("load_b", 32'(bus.Bval), 32'(v));
        chk("load_a", 32'(bus.Aval), 32'd0);
        chk("load_busy", 32'(bus.Busy), 32'd0);
    endtask

    task automatic run_mult(input string tag, input logic [7:0] s, input int hold);
        int   ps, pb, pr, lat, lat_exp, sub_cnt, sub_at, busy_gaps, hold_bad;
        logic [15:0] prod;
        ps      = $signed(s);
        pb      = $signed(b_ref);
        pr      = ps * pb;
        prod    = pr[15:0];
        lat_exp = exp_latency(b_ref);
        lat = 0; sub_cnt = 0; sub_at = 0; busy_gaps = 0; hold_bad = 0;
        bus.Run = 1'b1;
        bus.Din = s;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1) bus.Din = ~s;
            bus.ClearA_LoadB = (k == 2);
            if (bus.Done) begin
                lat = k;
                break;
            end
            if (bus.add_sub) begin
                sub_cnt++;
                sub_at = k;
            end
            if (!bus.Busy) busy_gaps++;
        end
        bus.ClearA_LoadB = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_A"}, 32'(bus.Aval), 32'(prod[15:8]));
        chk({tag, "_B"}, 32'(bus.Bval), 32'(prod[7:0]));
        chk({tag, "_X"}, 32'(bus.X), 32'(prod[15]));
        chk({tag, "_busy"}, 32'(busy_gaps), 32'd0);
        chk({tag, "_sub_cnt"}, 32'(sub_cnt), 32'd1);
        chk({tag, "_sub_edge"}, 32'(sub_at), 32'(exp_sub_edge(b_ref, lat_exp)));
        b_ref = prod[7:0];
        for (int h = 0; h < hold; h++) begin
            step();
            if (!bus.Done || bus.Busy || bus.Bval !== prod[7:0]) hold_bad++;
        end
        chk({tag, "_hold"}, 32'(hold_bad), 32'd0);
        bus.Run = 1'b0;
        step();
        chk({tag, "_idle_done"}, 32'(bus.Done), 32'd0);
        chk({tag, "_idle_B"}, 32'(bus.Bval), 32'(prod[7:0]));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        b_ref = 8'h00;
        Reset_n          = 1'b0;
        bus.Run          = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        bus.Din          = 8'h00;
        step();
        step();
        chk("rst_A", 32'(bus.Aval), 32'd0);
        chk("rst_B", 32'(bus.Bval), 32'd0);
        chk("rst_X", 32'(bus.X), 32'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_sub", 32'(bus.add_sub), 32'd0);
        Reset_n = 1'b1;
        step();

        // 7 * -3 = -21, then chained -21 * 1 with Run held in DONE.
        load_b(8'h07);
        run_mult("t1", 8'hFD, 0);
        chk("t1_const", 32'({bus.X, bus.Aval, bus.Bval}), 32'h1FFEB);
        run_mult("t4", 8'h01, 5);
        chk("t4_const", 32'({bus.Aval, bus.Bval}), 32'hFFEB);

        load_b(8'hFE);
        run_mult("t2", 8'hFD, 0);
        chk("t2_const", 32'({bus.X, bus.Aval, bus.Bval}), 32'h00006);

        load_b(8'h80);
        run_mult("t3", 8'h80, 0);
        chk("t3_const", 32'({bus.X, bus.Aval, bus.Bval}), 32'h04000);

        load_b(8'h01);
        run_mult("t6a", 8'h05, 0);
        load_b(8'h00);
        run_mult("t6b", 8'h5A, 0);

        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 3) != 0) load_b(8'($urandom));
            run_mult("rnd", 8'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a multiply, then load and run asserted together.
        load_b(8'h6B);
        bus.Run = 1'b1;
        bus.Din = 8'h39;
        repeat (8) step();
        chk("mid_busy", 32'(bus.Busy), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_A", 32'(bus.Aval), 32'd0);
        chk("mid_rst_B", 32'(bus.Bval), 32'd0);
        chk("mid_rst_X", 32'(bus.X), 32'd0);
        chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
        chk("mid_rst_done", 32'(bus.Done), 32'd0);
        bus.Run = 1'b0;
        step();
        Reset_n = 1'b1;
        step();
        bus.ClearA_LoadB = 1'b1;
        bus.Run          = 1'b1;
        bus.Din          = 8'h5A;
        step();
        chk("prio_B", 32'(bus.Bval), 32'h5A);
        chk("prio_busy1", 32'(bus.Busy), 32'd0);
        step();
        chk("prio_busy2", 32'(bus.Busy), 32'd0);
        bus.ClearA_LoadB = 1'b0;
        bus.Run          = 1'b0;
        b_ref            = 8'h5A;
        step();
        run_mult("post_rst", 8'h9C, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_add_mult_seq.md
Name: shift_add_mult_seq

Overview:
Sequencer and register file for the 8x8 signed (two's-complement) shift-add multiplier. It owns the X, A and B registers and the multiplicand latch. It drives operands into the external 9-bit add/subtract stage and consumes that stage's 9-bit sum. The 16-bit product is held in A:B, with the sign extension in X.

Parameters:
WIDTH, 8, operand width. Only 8 is supported because the paired adder is fixed at 8+1 bits. Any other value is a synthesis error.

Ports:
Clk  in  1  clock; all state updates on rising edge.
Reset_n  in  1  asynchronous, active-low reset.
Run  in  1  level request to start a multiply.
ClearA_LoadB  in  1  level; in IDLE: A<=0, X<=0, B<=Din.
Din  in  8  multiplier source (B load) and multiplicand source (S latch).
add_sum  in  9  result from the add/subtract stage.
add_a  out  8  operand A to the adder; equals the A register.
add_b  out  8  operand B to the adder; equals the S latch.
add_sub  out  1  1 = adder computes A - S.
Aval  out  8  A register (product high byte).
Bval  out  8  B register (product low byte).
X  out  1  sign-extension bit.
Busy  out  1  high in ADD/SHIFT.
Done  out  1  high in DONE.

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; A, B, S, X and cnt all 0. All outputs 0.
- States: IDLE, ADD, SHIFT, DONE. cnt is a 3-bit iteration counter.
- IDLE:
  - ClearA_LoadB=1: A<=0, X<=0, B<=Din; stay in IDLE. This has priority over Run in the same cycle.
  - else Run=1: S<=Din, A<=0, X<=0, cnt<=0; go to ADD. B is retained, so a multiply can be chained on the previous low byte.
- ADD:
  - add_sub = (cnt==7).
  - If B[0]=1: X<=add_sum[8], A<=add_sum[7:0].
  - If B[0]=0: A and X are unchanged.
  - Next state: SHIFT.
- SHIFT (arithmetic right shift of X:A:B):
  - X unchanged; A<={X,A[7:1]}; B<={A[0],B[7:1]}.
  - If cnt==7: go to DONE. Else cnt<=cnt+1 and go to ADD.
- DONE: all registers hold. Leave for IDLE only when Run=0. Holding Run high never restarts a multiply.
- add_sub=0 in every state except ADD with cnt==7.
- add_a and add_b are driven continuously; the adder result is only used in ADD.
- Latency: Done rises exactly 17 rising edges after the edge that samples Run=1 in IDLE (8 ADD + 8 SHIFT + 1).
- Run, ClearA_LoadB and Din are ignored in ADD and SHIFT. Din is not re-sampled mid-operation.
- Reset asserted mid-operation: immediate return to IDLE with all registers zero. No partial result is retained.
- Result: {A,B} is the signed 16-bit product of S and the original B. X equals A[7] at DONE.

Optional Feature:
Macro: MULT_ZERO_SKIP_EN.
- Defined: in ADD with B[0]=0, the shift is performed in the same cycle (the SHIFT update rule applied) and the cnt/DONE decision is taken there, so SHIFT is skipped for that iteration. Latency = 9 + popcount(original B) edges.
- Undefined: fixed 17-edge latency as specified above.
- Final register values are identical in both builds.

Test Plan:
1. ClearA_LoadB with Din=0x07, then Run with Din=0xFD (-3) -> at Done: A=0xFF, B=0xEB, X=1 (-21). Done exactly 17 edges after Run is sampled (macro off).
2. Load B=0xFE (-2), Run with Din=0xFD (-3) -> A=0x00, B=0x06, X=0. add_sub=1 only in the cnt==7 ADD cycle.
3. Load B=0x80, Run with Din=0x80 -> A=0x40, B=0x00, X=0 (+16384). Covers the subtract-on-last-bit corner.
4. After test 1, drop Run, then Run with Din=0x01, no reload -> A=0xFF, B=0xEB (chained multiply). Holding Run high in DONE for 5 cycles causes no restart.
5. Assert Reset_n=0 at cnt==3 in SHIFT -> same-cycle return to IDLE; A, B, X, Busy and Done all 0. ClearA_LoadB and Run asserted together in IDLE -> load only, stays in IDLE.
6. MULT_ZERO_SKIP_EN defined, B=0x01, S=0x05 -> A=0x00, B=0x05, Done at edge 10. B=0x00 -> product 0, Done at edge 9.
